// File: rtl/cnn_config_reader_if.sv
// ----------------------------------------------------------------------------
// cnn_config_reader_if
//
// Read-port bundle between the configuration reader and the parameter RAM.
//
// Signals:
//   ram_addr   reader -> RAM  word address
//   ram_rd     reader -> RAM  read strobe; data returns the following cycle
//   ram_rdata  RAM -> reader  read data, valid the cycle after ram_rd
//
// Modports:
//   master  the reader side (drives address/strobe, receives data)
//   slave   the RAM side (receives address/strobe, drives data)
// ----------------------------------------------------------------------------
interface cnn_config_reader_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [DW-1:0] ram_rdata;

    modport master (
        output ram_addr,
        output ram_rd,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_rd,
        output ram_rdata
    );
endinterface

// File: rtl/cnn_config_reader.sv
// ----------------------------------------------------------------------------
// cnn_config_reader
//
// Walks the CNN configuration header held in parameter RAM after a start
// pulse, checks it for consistency, latches the per-layer fields into a local
// register file and derives each conv layer's filter base address. The
// latched fields are served to the layer sequencer through a registered
// query port.
//
// RAM header layout (N = word 1):
//   0 filter_size, 1 N, 2 filter offset, 3 dense offset,
//   4..N+3 filter count per layer, N+4..2N+3 layer type per layer,
//   2N+4..4N+1 (N-1) pairs of {dense count, weight count}.
//
// Ports:
//   clk, RST                 clock and synchronous active-high reset
//   start                    one-cycle parse request (honoured only when idle)
//   busy                     parse in progress
//   done                     one-cycle pulse at the end of a parse
//   cfg_valid                last parse passed all checks
//   err                      0 ok, 1 bad layer count, 2 bad filter offset,
//                            3 dense offset mismatch
//   ram                      parameter RAM read port (master side)
//   filter_size, num_layers,
//   filter_base, dense_base  header words 0..3 as captured
//   layer_sel                layer index to query
//   layer_nfilt, layer_type,
//   layer_ndense, layer_nweight,
//   layer_faddr              fields of layer_sel, one cycle after layer_sel
// ----------------------------------------------------------------------------
module cnn_config_reader #(
    parameter int MAX_LAYERS = 10,
    parameter int AW         = 16,
    parameter int DW         = 16
) (
    input  logic                clk,
    input  logic                RST,

    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                cfg_valid,
    output logic [1:0]          err,

    cnn_config_reader_if.master ram,

    output logic [DW-1:0]       filter_size,
    output logic [DW-1:0]       num_layers,
    output logic [DW-1:0]       filter_base,
    output logic [DW-1:0]       dense_base,

    input  logic [3:0]          layer_sel,
    output logic [DW-1:0]       layer_nfilt,
    output logic [DW-1:0]       layer_type,
    output logic [DW-1:0]       layer_ndense,
    output logic [DW-1:0]       layer_nweight,
    output logic [DW-1:0]       layer_faddr
);

    localparam int IW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_HDR,
        S_RD_NF,
        S_RD_TYPE,
        S_RD_DENSE,
        S_ACCUM,
        S_CHECK,
        S_FAIL
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q;
    logic            phase_q;      // 0: issue cycle, 1: capture cycle
    logic [IW-1:0]   idx_q;        // layer index within the current section
    logic            sub_q;        // 0: dense count, 1: weight count
    logic            busy_q;
    logic            done_q;
    logic            cfg_valid_q;
    logic [1:0]      err_q;
    logic            ram_rd_q;
    logic [AW-1:0]   ram_addr_q;

    logic [DW-1:0]   fs_q;
    logic [DW-1:0]   nl_q;
    logic [DW-1:0]   fb_q;
    logic [DW-1:0]   db_q;
    logic [DW-1:0]   acc_q;        // running filter address

    logic [DW-1:0]   nf_q  [MAX_LAYERS];
    logic [DW-1:0]   typ_q [MAX_LAYERS];
    logic [DW-1:0]   nd_q  [MAX_LAYERS];
    logic [DW-1:0]   nw_q  [MAX_LAYERS];
    logic [DW-1:0]   fa_q  [MAX_LAYERS];

    logic [DW-1:0]   q_nfilt_q;
    logic [DW-1:0]   q_type_q;
    logic [DW-1:0]   q_ndense_q;
    logic [DW-1:0]   q_nweight_q;
    logic [DW-1:0]   q_faddr_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [IW-1:0]   last_idx_d;
    logic            n_bad_d;
    logic [DW-1:0]   fb_exp_d;
    logic [DW-1:0]   prod1_d;
    logic [DW-1:0]   prod2_d;
    logic [DW-1:0]   acc_d;
    logic            sel_ok_d;
    logic            sel_last_d;

    always_comb begin
        // Only meaningful once N has passed the range check (1..MAX_LAYERS).
        last_idx_d = nl_q[IW-1:0] - IW'(1);
        n_bad_d    = (ram.ram_rdata == '0) || (ram.ram_rdata > DW'(MAX_LAYERS));
        // The filter block starts right after the last header word (4N+1).
        fb_exp_d   = {nl_q[DW-3:0], 2'b00} + DW'(2);
        // nf*fs*fs truncated to DW bits; truncating each step gives the same
        // result modulo 2^DW.
        prod1_d    = nf_q[idx_q] * fs_q;
        prod2_d    = prod1_d * fs_q;
        acc_d      = acc_q + nf_q[idx_q] + prod2_d;
        sel_ok_d   = (DW'(layer_sel) < nl_q) && (int'(layer_sel) < MAX_LAYERS);
        sel_last_d = (DW'(layer_sel) == nl_q - DW'(1));
    end

    // ------------------------------------------------------------------------
    // Parse FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            idx_q       <= '0;
            sub_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            err_q       <= 2'd0;
            ram_rd_q    <= 1'b0;
            ram_addr_q  <= '0;
            fs_q        <= '0;
            nl_q        <= '0;
            fb_q        <= '0;
            db_q        <= '0;
            acc_q       <= '0;
            for (int i = 0; i < MAX_LAYERS; i++) begin
                nf_q[i]  <= '0;
                typ_q[i] <= '0;
                nd_q[i]  <= '0;
                nw_q[i]  <= '0;
                fa_q[i]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    // done_q high here means a pass just completed; a start
                    // coincident with that done pulse is dropped.
                    if (start && !done_q) begin
                        state_q     <= S_RD_HDR;
                        busy_q      <= 1'b1;
                        cfg_valid_q <= 1'b0;
                        err_q       <= 2'd0;
                        ram_rd_q    <= 1'b1;
                        ram_addr_q  <= '0;
                        phase_q     <= 1'b0;
                        idx_q       <= '0;
                        sub_q       <= 1'b0;
                    end
                end

                S_RD_HDR, S_RD_NF, S_RD_TYPE, S_RD_DENSE: begin
                    if (!phase_q) begin
                        ram_rd_q <= 1'b0;
                        phase_q  <= 1'b1;
                    end else begin
                        // Capture cycle: by default issue the next word; the
                        // branches below stop the walk where needed.
                        phase_q    <= 1'b0;
                        ram_rd_q   <= 1'b1;
                        ram_addr_q <= ram_addr_q + AW'(1);
                        case (state_q)
                            S_RD_HDR: begin
                                case (ram_addr_q[1:0])
                                    2'd0: fs_q <= ram.ram_rdata;
                                    2'd1: begin
                                        nl_q <= ram.ram_rdata;
                                        if (n_bad_d) begin
                                            state_q    <= S_FAIL;
                                            ram_rd_q   <= 1'b0;
                                            ram_addr_q <= ram_addr_q;
                                            done_q     <= 1'b1;
                                            err_q      <= 2'd1;
                                        end
                                    end
                                    2'd2: begin
                                        fb_q  <= ram.ram_rdata;
                                        acc_q <= ram.ram_rdata;
                                        if (ram.ram_rdata != fb_exp_d) begin
                                            state_q    <= S_FAIL;
                                            ram_rd_q   <= 1'b0;
                                            ram_addr_q <= ram_addr_q;
                                            done_q     <= 1'b1;
                                            err_q      <= 2'd2;
                                        end
                                    end
                                    default: begin
                                        db_q    <= ram.ram_rdata;
                                        state_q <= S_RD_NF;
                                        idx_q   <= '0;
                                    end
                                endcase
                            end

                            S_RD_NF: begin
                                nf_q[idx_q] <= ram.ram_rdata;
                                if (idx_q == last_idx_d) begin
                                    state_q <= S_RD_TYPE;
                                    idx_q   <= '0;
                                end else begin
                                    idx_q <= idx_q + IW'(1);
                                end
                            end

                            S_RD_TYPE: begin
                                typ_q[idx_q] <= ram.ram_rdata;
                                if (idx_q == last_idx_d) begin
                                    idx_q <= '0;
                                    sub_q <= 1'b0;
                                    if (last_idx_d == '0) begin
                                        // Single layer: no dense/weight pairs.
                                        state_q    <= S_ACCUM;
                                        ram_rd_q   <= 1'b0;
                                        ram_addr_q <= ram_addr_q;
                                    end else begin
                                        state_q <= S_RD_DENSE;
                                    end
                                end else begin
                                    idx_q <= idx_q + IW'(1);
                                end
                            end

                            default: begin  // S_RD_DENSE
                                if (!sub_q) begin
                                    nd_q[idx_q] <= ram.ram_rdata;
                                    sub_q       <= 1'b1;
                                end else begin
                                    nw_q[idx_q] <= ram.ram_rdata;
                                    sub_q       <= 1'b0;
                                    // Pairs exist for layers 0..N-2 only.
                                    if (idx_q == last_idx_d - IW'(1)) begin
                                        state_q    <= S_ACCUM;
                                        ram_rd_q   <= 1'b0;
                                        ram_addr_q <= ram_addr_q;
                                        idx_q      <= '0;
                                    end else begin
                                        idx_q <= idx_q + IW'(1);
                                    end
                                end
                            end
                        endcase
                    end
                end

                S_ACCUM: begin
                    fa_q[idx_q] <= acc_q;
                    acc_q       <= acc_d;
                    if (idx_q == last_idx_d) begin
                        state_q <= S_CHECK;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end

                S_CHECK: begin
                    // busy stays high through the done cycle; IDLE drops it.
                    state_q     <= S_IDLE;
                    done_q      <= 1'b1;
                    cfg_valid_q <= (acc_q == db_q);
                    err_q       <= (acc_q == db_q) ? 2'd0 : 2'd3;
                end

                default: begin  // S_FAIL: done is already high this cycle
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered query port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            q_nfilt_q   <= '0;
            q_type_q    <= '0;
            q_ndense_q  <= '0;
            q_nweight_q <= '0;
            q_faddr_q   <= '0;
        end else if (sel_ok_d) begin
            q_nfilt_q <= nf_q[layer_sel];
            q_type_q  <= typ_q[layer_sel];
            q_faddr_q <= fa_q[layer_sel];
            // The last layer has no dense/weight pair; its slot may hold
            // stale values from an earlier, longer header.
            if (sel_last_d) begin
                q_ndense_q  <= '0;
                q_nweight_q <= '0;
            end else begin
                q_ndense_q  <= nd_q[layer_sel];
                q_nweight_q <= nw_q[layer_sel];
            end
        end else begin
            q_nfilt_q   <= '0;
            q_type_q    <= '0;
            q_ndense_q  <= '0;
            q_nweight_q <= '0;
            q_faddr_q   <= '0;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_valid     = cfg_valid_q;
    assign err           = err_q;
    assign ram.ram_rd    = ram_rd_q;
    assign ram.ram_addr  = ram_addr_q;
    assign filter_size   = fs_q;
    assign num_layers    = nl_q;
    assign filter_base   = fb_q;
    assign dense_base    = db_q;
    assign layer_nfilt   = q_nfilt_q;
    assign layer_type    = q_type_q;
    assign layer_ndense  = q_ndense_q;
    assign layer_nweight = q_nweight_q;
    assign layer_faddr   = q_faddr_q;

endmodule

// File: tb/tb_cnn_config_reader.sv
// ----------------------------------------------------------------------------
// tb_cnn_config_reader
//
// Directed bench for cnn_config_reader. A small RAM model answers reads one
// cycle after ram_rd and drives random data on every other cycle. Cycle 0 is
// the cycle in which start is sampled.
// ----------------------------------------------------------------------------
module tb_cnn_config_reader;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, cfg_valid;
    logic [1:0]    err;
    logic [DW-1:0] filter_size, num_layers, filter_base, dense_base;
    logic [3:0]    layer_sel = 4'd0;
    logic [DW-1:0] layer_nfilt, layer_type, layer_ndense, layer_nweight, layer_faddr;

    logic [15:0]   mem [0:63];
    int            checks = 0;
    int            errors = 0;
    int            dcyc, rdc;
    logic          bok, bpost;

    cnn_config_reader_if #(.AW(AW), .DW(DW)) rif ();

    cnn_config_reader #(.MAX_LAYERS(10), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .RST          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .cfg_valid    (cfg_valid),
        .err          (err),
        .ram          (rif),
        .filter_size  (filter_size),
        .num_layers   (num_layers),
        .filter_base  (filter_base),
        .dense_base   (dense_base),
        .layer_sel    (layer_sel),
        .layer_nfilt  (layer_nfilt),
        .layer_type   (layer_type),
        .layer_ndense (layer_ndense),
        .layer_nweight(layer_nweight),
        .layer_faddr  (layer_faddr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rif.ram_rd) rif.ram_rdata <= mem[rif.ram_addr[5:0]];
        else            rif.ram_rdata <= 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_nominal();
        for (int i = 0; i < 64; i++) mem[i] = 16'hDEAD;
        mem[0] = 16'd1;  mem[1] = 16'd3;  mem[2] = 16'd14; mem[3] = 16'd50;
        mem[4] = 16'd6;  mem[5] = 16'd6;  mem[6] = 16'd6;
        mem[7] = 16'd0;  mem[8] = 16'd1;  mem[9] = 16'd1;
        mem[10] = 16'd12; mem[11] = 16'd12; mem[12] = 16'd12; mem[13] = 16'd12;
    endtask

    // Pulses start in cycle 0, then watches cycles 1..max_cyc. Optionally
    // re-pulses start in cycle pulse_cyc and asserts reset in cycle rst_cyc.
    task automatic do_parse(input int pulse_cyc, input int rst_cyc, input int max_cyc,
                            output int done_cyc, output int rd_cnt,
                            output logic busy_ok, output logic busy_post);
        done_cyc  = -1;
        rd_cnt    = 0;
        busy_ok   = 1'b1;
        busy_post = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            start = (k == pulse_cyc);
            rst   = (k == rst_cyc);
            if (k == rst_cyc + 1) busy_post = busy;
            if (rif.ram_rd) rd_cnt++;
            if (k <= rst_cyc && !busy) busy_ok = 1'b0;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic query(input logic [3:0] sel);
        @(negedge clk);
        layer_sel = sel;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_ram_rd", rif.ram_rd, 0);
        chk("rst_ram_addr", rif.ram_addr, 0);
        chk("rst_num_layers", num_layers, 0);
        chk("rst_faddr", layer_faddr, 0);

        // Nominal header
        load_nominal();
        do_parse(0, 1000, 60, dcyc, rdc, bok, bpost);
        chk("nom_done_cyc", dcyc, 33);
        chk("nom_err", err, 0);
        chk("nom_cfg_valid", cfg_valid, 1);
        chk("nom_rd_cnt", rdc, 14);
        chk("nom_busy", bok, 1);
        chk("nom_fs", filter_size, 1);
        chk("nom_nl", num_layers, 3);
        chk("nom_fb", filter_base, 14);
        chk("nom_db", dense_base, 50);
        // start coincident with done must be dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_done_ignored", busy, 0);

        // Query sweep
        query(4'd0);
        chk("q0_faddr", layer_faddr, 14);
        chk("q0_type", layer_type, 0);
        chk("q0_ndense", layer_ndense, 12);
        query(4'd1);
        chk("q1_faddr", layer_faddr, 26);
        chk("q1_nfilt", layer_nfilt, 6);
        chk("q1_type", layer_type, 1);
        chk("q1_ndense", layer_ndense, 12);
        chk("q1_nweight", layer_nweight, 12);
        query(4'd2);
        chk("q2_faddr", layer_faddr, 38);
        chk("q2_nfilt", layer_nfilt, 6);
        chk("q2_ndense", layer_ndense, 0);
        chk("q2_nweight", layer_nweight, 0);
        query(4'd5);
        chk("q5_all_zero", layer_nfilt | layer_type | layer_ndense | layer_nweight | layer_faddr, 0);

        // Bad layer count
        load_nominal();
        mem[1] = 16'd0;
        do_parse(0, 1000, 40, dcyc, rdc, bok, bpost);
        chk("n0_done_cyc", dcyc, 5);
        chk("n0_err", err, 1);
        chk("n0_rd_cnt", rdc, 2);
        chk("n0_cfg_valid", cfg_valid, 0);

        load_nominal();
        mem[1] = 16'd11;
        do_parse(0, 1000, 40, dcyc, rdc, bok, bpost);
        chk("n11_done_cyc", dcyc, 5);
        chk("n11_err", err, 1);

        // N=10 is legal; word 2 then fails the offset check instead
        load_nominal();
        mem[1] = 16'd10;
        do_parse(0, 1000, 40, dcyc, rdc, bok, bpost);
        chk("n10_done_cyc", dcyc, 7);
        chk("n10_err", err, 2);

        // Offset faults
        load_nominal();
        mem[2] = 16'd15;
        do_parse(0, 1000, 40, dcyc, rdc, bok, bpost);
        chk("fb_done_cyc", dcyc, 7);
        chk("fb_err", err, 2);
        chk("fb_rd_cnt", rdc, 3);

        load_nominal();
        mem[3] = 16'd51;
        do_parse(0, 1000, 60, dcyc, rdc, bok, bpost);
        chk("db_done_cyc", dcyc, 33);
        chk("db_err", err, 3);
        chk("db_cfg_valid", cfg_valid, 0);

        // Arithmetic wrap: fs=3, N=2, nf={0x2000,1}
        load_nominal();
        mem[0] = 16'd3;  mem[1] = 16'd2;  mem[2] = 16'd10; mem[3] = 16'h4014;
        mem[4] = 16'h2000; mem[5] = 16'd1;
        mem[6] = 16'd0;  mem[7] = 16'd1;
        mem[8] = 16'd5;  mem[9] = 16'd7;
        do_parse(0, 1000, 60, dcyc, rdc, bok, bpost);
        chk("wrap_done_cyc", dcyc, 24);
        chk("wrap_err", err, 0);
        chk("wrap_cfg_valid", cfg_valid, 1);
        chk("wrap_rd_cnt", rdc, 10);
        query(4'd0);
        chk("wrap_q0_faddr", layer_faddr, 10);
        chk("wrap_q0_ndense", layer_ndense, 5);
        chk("wrap_q0_nweight", layer_nweight, 7);
        query(4'd1);
        chk("wrap_q1_faddr", layer_faddr, 16'h400A);
        chk("wrap_q1_ndense", layer_ndense, 0);
        query(4'd2);
        chk("wrap_q2_zero", layer_nfilt | layer_faddr | layer_ndense, 0);

        // start pulsed mid-parse is ignored
        load_nominal();
        do_parse(10, 1000, 60, dcyc, rdc, bok, bpost);
        chk("midstart_done_cyc", dcyc, 33);
        chk("midstart_err", err, 0);
        chk("midstart_cfg_valid", cfg_valid, 1);
        chk("midstart_rd_cnt", rdc, 14);
        query(4'd2);
        chk("midstart_q2_faddr", layer_faddr, 38);

        // Reset mid-parse
        do_parse(0, 12, 45, dcyc, rdc, bok, bpost);
        chk("rst_mid_no_done", dcyc, -1);
        chk("rst_mid_busy", bpost, 0);
        chk("rst_mid_cfg_valid", cfg_valid, 0);
        chk("rst_mid_nl", num_layers, 0);
        chk("rst_mid_ram_rd", rif.ram_rd, 0);

        // Fresh start after reset
        do_parse(0, 1000, 60, dcyc, rdc, bok, bpost);
        chk("fresh_done_cyc", dcyc, 33);
        chk("fresh_err", err, 0);
        chk("fresh_cfg_valid", cfg_valid, 1);
        query(4'd1);
        chk("fresh_q1_faddr", layer_faddr, 26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnn_config_reader.md
# cnn_config_reader

Reads the CNN configuration header from parameter RAM and serves it to the datapath. The header is written by the load path before inference. After a `start` pulse the block walks the header words and checks them for consistency. It latches every per-layer field into a local register file and computes each conv layer's filter base address. It sits between the parameter RAM read port and the coordinator's layer-sequencing logic.

## Interface
- `MAX_LAYERS`, 10: register-file depth; legal `num_layers` is 1..MAX_LAYERS.
- `AW`, 16: RAM address width.
- `DW`, 16: RAM data width; all fields are DW bits.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle request to parse the header; ignored unless idle.
- `busy` out 1: a parse is in progress.
- `done` out 1: one-cycle pulse when a parse finishes, pass or fail.
- `cfg_valid` out 1: level; the last parse passed.
- `err` out 2: 0 = ok, 1 = bad layer count, 2 = bad filter offset, 3 = dense offset mismatch.
- `ram_addr` out AW: read address.
- `ram_rd` out 1: read strobe.
- `ram_rdata` in DW: read data, valid the cycle after `ram_rd`.
- `filter_size`, `num_layers`, `filter_base`, `dense_base` out DW each: header words 0..3.
- `layer_sel` in 4: layer index to query.
- `layer_nfilt`, `layer_type`, `layer_ndense`, `layer_nweight`, `layer_faddr` out DW each: fields for `layer_sel`.

## Operation
- RAM header layout, with N = word 1:
  - word 0 `filter_size`, word 1 N, word 2 filter offset, word 3 dense offset;
  - words 4..N+3: filter count per layer;
  - words N+4..2N+3: layer type per layer;
  - words 2N+4 onward: (N-1) pairs of {dense count, weight count}.
  - The last word is at address 4N+1.
- FSM states: IDLE -> RD_HDR -> RD_NF -> RD_TYPE -> RD_DENSE -> ACCUM -> CHECK -> IDLE. Every fault goes to FAIL -> IDLE.
- Each word takes 2 cycles. In the issue cycle `ram_rd`=1 and `ram_addr` = word address. In the capture cycle `ram_rd`=0 and `ram_rdata` is registered.
- Word 1 check: N=0 or N>MAX_LAYERS -> FAIL with err=1.
- Word 2 check: word 2 ≠ 4N+2 -> FAIL with err=2.
- The remaining reads are not issued after a FAIL.
- ACCUM takes one cycle per layer i = 0..N-1:
  - faddr[0] = word 2;
  - faddr[i+1] = faddr[i] + nf[i] + nf[i]·fs·fs.
- Arithmetic is modulo 2^DW and the product is truncated to DW bits. Overflow is not flagged.
- CHECK: faddr[N] ≠ word 3 -> err=3, otherwise err=0.
- The N-1 dense/weight pairs are not cross-checked.
- Query port:
  - outputs are registered and reflect `layer_sel` one cycle later;
  - for index ≥ N, all five outputs are 0;
  - for index N-1, `layer_ndense` = `layer_nweight` = 0.
- `cfg_valid` clears on `start` acceptance. It sets with `done` only when err=0.
- Header outputs update as each word is captured.

## Timing
- Reset values:
  - `busy`, `done`, `cfg_valid`, `ram_rd` = 0;
  - `err`, `ram_addr` = 0;
  - all header and query outputs = 0; register-file contents are cleared.
- Start is sampled in cycle 0. The first `ram_rd` is in cycle 1. `busy`=1 from cycle 1 until the cycle `done` is high, inclusive.
- Pass latency:
  - the last capture is in cycle 8N+4;
  - ACCUM runs in cycles 8N+5..9N+4;
  - CHECK is cycle 9N+5;
  - `done` and final `err`/`cfg_valid` are in cycle 9N+6.
  - For N=3, `done` is in cycle 33.
- err=1: `done` in cycle 5. err=2: `done` in cycle 7. No `ram_rd` is issued after the failing capture.
- `start` while busy is ignored. `start` in the same cycle as `done` is ignored.
- `RST` mid-parse: FSM goes to IDLE next cycle with all outputs at reset values. No `done` pulse.
- `ram_rdata` is sampled only in capture cycles; other values are ignored.

## Test plan
- Nominal header: fs=1, N=3, word2=14, word3=50, nf={6,6,6}, type={0,1,1}, dense/weight pairs {12,12},{12,12}.
  - Expect `done` at cycle 33 with err=0 and `cfg_valid`=1.
  - Expect `layer_faddr` = 14, 26, 38 for layers 0, 1, 2.
- Query sweep after the nominal parse:
  - `layer_sel`=1 -> nfilt=6, type=1, ndense=12, nweight=12 one cycle later;
  - `layer_sel`=2 -> ndense=0;
  - `layer_sel`=5 -> all 0.
- Bad layer count:
  - word1=0 -> err=1, `done` at cycle 5, exactly 2 `ram_rd` pulses;
  - word1=11 -> err=1.
- Offset faults:
  - word2=15 with N=3 -> err=2 at cycle 7;
  - word3=51 -> err=3 at cycle 33 with `cfg_valid`=0.
- Arithmetic wrap: fs=3, nf[0]=0x2000.
  - Expect faddr[1] = (word2 + 0x2000 + 0x12000) mod 2^16 = word2 + 0x4000.
- Control corners:
  - `start` pulsed at cycle 10 of a parse -> ignored, with identical results;
  - `RST` at cycle 12 -> IDLE, `busy`=0, no `done`;
  - a fresh `start` then gives a clean pass.
